// File: rtl/fp_mult_seq.sv
// Sequential single-precision-layout floating-point multiplier.
// One shift-add multiplier step per cycle, then a normalize cycle and a
// rounding cycle. Zero/denormal operands flush to signed zero and an
// all-ones exponent forces a signed infinity without running the multiplier.
module fp_mult_seq #(
    parameter int MANT_W = 24,
    parameter int EXP_W  = 8
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W-1:0] a,
    input  logic [EXP_W+MANT_W-1:0] b,
    input  logic [1:0]              mode,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [EXP_W+MANT_W-1:0] result,
    output logic                    inexact,
    output logic                    overflow,
    output logic                    underflow
);

    localparam int W  = EXP_W + MANT_W;      // operand/result width
    localparam int FW = MANT_W - 1;          // stored fraction width
    localparam int PW = 2 * MANT_W;          // full product width
    localparam int XW = EXP_W + 2;           // signed working exponent width
    localparam int CW = $clog2(MANT_W + 1);  // multiplier step counter width

    localparam logic signed [XW-1:0] BIAS     = XW'((1 << (EXP_W - 1)) - 1);
    localparam logic signed [XW-1:0] EXP_MAX  = XW'((1 << EXP_W) - 1);
    localparam logic signed [XW-1:0] EXP_ONE  = XW'(1);
    localparam logic signed [XW-1:0] EXP_ZERO = '0;
    localparam logic [CW-1:0]        LAST_STEP = CW'(MANT_W - 1);

    typedef enum logic [2:0] {
        IDLE,
        MUL,
        NORM,
        ROUND,
        DONE
    } state_t;

    state_t state_reg;
    state_t state_next;

    // Captured operation
    logic                    sign_reg;
    logic [1:0]              mode_reg;
    logic [EXP_W-1:0]        exp_a_reg;
    logic [EXP_W-1:0]        exp_b_reg;
    logic [MANT_W-1:0]       mcand_reg;
    logic [MANT_W-1:0]       mplier_reg;

    // Working state
    logic [CW-1:0]           count_reg;
    logic [PW-1:0]           acc_reg;
    logic signed [XW-1:0]    exp_reg;

    // Registered outputs
    logic [W-1:0]            result_reg;
    logic                    inexact_reg;
    logic                    overflow_reg;
    logic                    underflow_reg;

    // Operand classification at the accept point
    logic [EXP_W-1:0] exp_a_in;
    logic [EXP_W-1:0] exp_b_in;
    logic             zero_in;
    logic             special_in;

    assign exp_a_in   = a[W-2:FW];
    assign exp_b_in   = b[W-2:FW];
    assign zero_in    = (exp_a_in == '0) || (exp_b_in == '0);
    assign special_in = (exp_a_in == '1) || (exp_b_in == '1);

    // Partial product for the current multiplier bit (MSB first)
    logic [PW-1:0] addend;
    genvar gi;
    generate
        for (gi = 0; gi < PW; gi++) begin : g_addend
            if (gi < MANT_W) begin : g_lo
                assign addend[gi] = mcand_reg[gi] & mplier_reg[MANT_W-1];
            end else begin : g_hi
                assign addend[gi] = 1'b0;
            end
        end
    endgenerate

    // Biased exponent of the product, bumped when the product is in [2,4)
    logic signed [XW-1:0] exp_norm;
    assign exp_norm = $signed({2'b00, exp_a_reg}) + $signed({2'b00, exp_b_reg})
                      - BIAS + (acc_reg[PW-1] ? EXP_ONE : EXP_ZERO);

    // Rounding of the normalized product; the hidden bit is always 1 here,
    // so only the fraction is incremented and its carry bumps the exponent
    logic                 guard_bit;
    logic                 sticky_bit;
    logic                 low_any;
    logic                 round_inc;
    logic [FW:0]          frac_sum;
    logic signed [XW-1:0] exp_fin;

    // Round-increment decision and final exponent
    always_comb begin
        guard_bit  = acc_reg[MANT_W-1];
        sticky_bit = |acc_reg[MANT_W-2:0];
        low_any    = guard_bit | sticky_bit;
        round_inc  = 1'b0;
        case (mode_reg)
            2'b00:   round_inc = 1'b0;
            2'b01:   round_inc = ~sign_reg & low_any;
            2'b10:   round_inc = sign_reg & low_any;
            default: round_inc = guard_bit & (sticky_bit | acc_reg[MANT_W]);
        endcase
        frac_sum = {1'b0, acc_reg[PW-2 -: FW]} + {{FW{1'b0}}, round_inc};
        exp_fin  = exp_reg + (frac_sum[FW] ? EXP_ONE : EXP_ZERO);
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next-state and handshake outputs
    always_comb begin
        state_next = state_reg;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        case (state_reg)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_next = (zero_in || special_in) ? DONE : MUL;
                end
            end
            MUL: begin
                if (count_reg == LAST_STEP) begin
                    state_next = NORM;
                end
            end
            NORM:  state_next = ROUND;
            ROUND: state_next = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Datapath: capture, shift-add, normalize, round and pack
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_reg      <= 1'b0;
            mode_reg      <= 2'b00;
            exp_a_reg     <= '0;
            exp_b_reg     <= '0;
            mcand_reg     <= '0;
            mplier_reg    <= '0;
            count_reg     <= '0;
            acc_reg       <= '0;
            exp_reg       <= '0;
            result_reg    <= '0;
            inexact_reg   <= 1'b0;
            overflow_reg  <= 1'b0;
            underflow_reg <= 1'b0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (in_valid) begin
                        sign_reg   <= a[W-1] ^ b[W-1];
                        mode_reg   <= mode;
                        exp_a_reg  <= exp_a_in;
                        exp_b_reg  <= exp_b_in;
                        mcand_reg  <= {1'b1, a[FW-1:0]};
                        mplier_reg <= {1'b1, b[FW-1:0]};
                        count_reg  <= '0;
                        acc_reg    <= '0;
                        if (zero_in) begin
                            result_reg    <= {a[W-1] ^ b[W-1], {(W-1){1'b0}}};
                            inexact_reg   <= 1'b0;
                            overflow_reg  <= 1'b0;
                            underflow_reg <= 1'b0;
                        end else if (special_in) begin
                            result_reg    <= {a[W-1] ^ b[W-1], {EXP_W{1'b1}}, {FW{1'b0}}};
                            inexact_reg   <= 1'b0;
                            overflow_reg  <= 1'b0;
                            underflow_reg <= 1'b0;
                        end
                    end
                end
                MUL: begin
                    acc_reg    <= {acc_reg[PW-2:0], 1'b0} + addend;
                    mplier_reg <= mplier_reg << 1;
                    count_reg  <= count_reg + 1'b1;
                end
                NORM: begin
                    if (!acc_reg[PW-1]) begin
                        acc_reg <= acc_reg << 1;
                    end
                    exp_reg <= exp_norm;
                end
                ROUND: begin
                    if (exp_fin >= EXP_MAX) begin
                        result_reg    <= {sign_reg, {EXP_W{1'b1}}, {FW{1'b0}}};
                        inexact_reg   <= 1'b1;
                        overflow_reg  <= 1'b1;
                        underflow_reg <= 1'b0;
                    end else if (exp_fin <= EXP_ZERO) begin
                        result_reg    <= {sign_reg, {(W-1){1'b0}}};
                        inexact_reg   <= 1'b1;
                        overflow_reg  <= 1'b0;
                        underflow_reg <= 1'b1;
                    end else begin
                        result_reg    <= {sign_reg, exp_fin[EXP_W-1:0], frac_sum[FW-1:0]};
                        inexact_reg   <= low_any;
                        overflow_reg  <= 1'b0;
                        underflow_reg <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign result    = result_reg;
    assign inexact   = inexact_reg;
    assign overflow  = overflow_reg;
    assign underflow = underflow_reg;

endmodule

// File: doc/fp_mult_seq.md
FP_MULT_SEQ -- requirements
Module: fp_mult_seq

Interface
REQ-001 SHALL have parameter MANT_W, default 24, meaning significand width including hidden bit.
REQ-002 SHALL have parameter EXP_W, default 8, meaning exponent width; bias = 2^(EXP_W-1)-1 (127).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port in_valid, input, 1 bit: operands a, b and mode are valid.
REQ-006 SHALL have port in_ready, output, 1 bit: block accepts operands this cycle.
REQ-007 SHALL have ports a and b, input, 1+EXP_W+MANT_W-1 bits (32): IEEE-754-layout operands.
REQ-008 SHALL have port mode, input, 2 bits: 00 toward zero, 01 toward +inf, 10 toward -inf, 11 nearest-even.
REQ-009 SHALL have port out_valid, output, 1 bit: result and flags are valid.
REQ-010 SHALL have port out_ready, input, 1 bit: consumer takes the result.
REQ-011 SHALL have port result, output, 32 bits: rounded product.
REQ-012 SHALL have ports inexact, overflow and underflow, output, 1 bit each: exception flags for result.

Function
REQ-013 SHALL implement FSM states IDLE, MUL, NORM, ROUND, DONE; in_ready = (state==IDLE); out_valid = (state==DONE).
REQ-014 SHALL accept on the edge where in_valid & in_ready, registering a, b, mode; later input changes SHALL be ignored.
REQ-015 On accept, if either exponent field is 0 SHALL go to DONE with result {sa^sb, 31'b0}, all flags 0 (zero/denormal flushed).
REQ-016 Else if either exponent field is all-ones SHALL go to DONE with result {sa^sb, 8'hFF, 23'b0}, flags 0; zero test takes priority.
REQ-017 Otherwise SHALL go to MUL with iteration counter 0 and a 2*MANT_W-bit accumulator cleared.
REQ-018 In MUL SHALL perform one shift-add step per cycle (one multiplier bit of {1,mant_b}), exactly MANT_W cycles, then NORM.
REQ-019 In NORM (1 cycle): if product bit 2*MANT_W-1 is set, the value is kept and exponent = ea+eb-bias+1; else the value is shifted left 1 and exponent = ea+eb-bias; exponent SHALL be computed with EXP_W+2 signed bits.
REQ-020 In ROUND (1 cycle) SHALL round the normalized product: high MANT_W bits kept; guard = next bit; sticky = OR of remaining bits; lsb = kept bit 0.
REQ-021 Increment rule: mode 00 none; 01 if sign=0 and any low bit set; 10 if sign=1 and any low bit set; 11 if guard & (sticky | lsb).
REQ-022 Rounding carry-out (kept bits all ones and increment) SHALL yield significand 1000...0 and exponent+1.
REQ-023 inexact SHALL be 1 iff any discarded low bit is nonzero.
REQ-024 Final exponent >= 255 SHALL give {sign, 8'hFF, 23'b0}, overflow=1, inexact=1.
REQ-025 Final exponent <= 0 SHALL give {sign, 31'b0}, underflow=1, inexact=1.
REQ-026 Otherwise result = {sign, exp[7:0], significand[MANT_W-2:0]}, overflow=underflow=0.
REQ-027 Latency SHALL be 26 cycles accept-edge to out_valid for normal operands (24 MUL + NORM + ROUND), and 1 cycle for REQ-015/016 cases.
REQ-028 In DONE, result and flags SHALL stay stable until the edge with out_ready=1, then go to IDLE; no new accept in that same cycle.
REQ-029 While busy (not IDLE), in_valid SHALL be ignored and in_ready SHALL be 0.

Reset
REQ-030 rst=1 SHALL immediately force IDLE, counter 0, accumulator 0, result 0, all flags 0, out_valid 0, in_ready 1, from any state including mid-MUL.
REQ-031 After rst deasserts, the first accept SHALL behave exactly as REQ-014.

Verification
REQ-032 0x3FC00000 x 0x40000000, mode 11 -> result 0x40400000, all flags 0, out_valid exactly 26 cycles after accept.
REQ-033 0x3F800001 x 0x3F800001 -> mode 00: 0x3F800002 inexact=1; mode 01: 0x3F800003; mode 10: 0x3F800002; mode 11: 0x3F800002.
REQ-034 0x00000000 x 0xC0000000 -> 0x80000000, flags 0, out_valid 1 cycle after accept.
REQ-035 0x7F000000 x 0x7F000000 -> 0x7F800000, overflow=1, inexact=1; 0x00800000 x 0x00800000 -> 0x00000000, underflow=1.
REQ-036 Hold out_ready=0 for 5 cycles in DONE -> result/flags stable, in_ready=0; out_ready=1 -> in_ready=1 next cycle; in_valid pulses during MUL are ignored.
REQ-037 Assert rst at MUL cycle 10 -> out_valid=0, in_ready=1 immediately; new operation then completes per REQ-032.
